// File: rtl/if_id_queue.sv
// Elastic IF/ID boundary: a DEPTH-entry FIFO of {pc, inst, pcIm} records feeding a
// registered ID-stage output slot, so IF can keep fetching while ID is stalled.
module if_id_queue #(
    parameter  int XLEN  = 32,
    parameter  int IMM_W = 12,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic             hazard_i,
    input  logic             push_i,
    output logic             ready_o,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  inst_i,
    input  logic [IMM_W-1:0] pcIm_i,
    output logic [XLEN-1:0]  pc_o,
    output logic [XLEN-1:0]  inst_o,
    output logic [IMM_W-1:0] pcIm_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [XLEN-1:0]  pc_mem_q   [DEPTH];
    logic [XLEN-1:0]  inst_mem_q [DEPTH];
    logic [IMM_W-1:0] pcim_mem_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  inst_q, inst_d;
    logic [IMM_W-1:0] pcim_q, pcim_d;
    logic             valid_q, valid_d;

    logic             ready_s;
    logic             push_acc_s;
    logic             wr_en_s;

    // Ready is derived from the registered count only, so a same-cycle pop never raises it
    assign ready_s    = (count_q < CNT_W'(DEPTH));
    assign push_acc_s = push_i & ready_s;

    // Next-state selection: flush > hazard > pop head > bypass > bubble
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        pcim_d   = pcim_q;
        valid_d  = valid_q;
        wr_en_s  = 1'b0;

        if (flush_i) begin
            rd_ptr_d = {PTR_W{1'b0}};
            wr_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
            pc_d     = pc_i;
            inst_d   = {XLEN{1'b0}};
            pcim_d   = {IMM_W{1'b0}};
            valid_d  = 1'b0;
        end else if (hazard_i) begin
            if (push_acc_s) begin
                wr_en_s  = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                count_d  = count_q + CNT_W'(1);
            end else begin
                count_d  = count_q;
            end
        end else if (count_q != {CNT_W{1'b0}}) begin
            pc_d     = pc_mem_q[rd_ptr_q];
            inst_d   = inst_mem_q[rd_ptr_q];
            pcim_d   = pcim_mem_q[rd_ptr_q];
            valid_d  = 1'b1;
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push_acc_s) begin
                wr_en_s  = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                count_d  = count_q;
            end else begin
                count_d  = count_q - CNT_W'(1);
            end
        end else if (push_acc_s) begin
            // Empty queue: the fetched record goes straight to the output slot
            pc_d    = pc_i;
            inst_d  = inst_i;
            pcim_d  = pcIm_i;
            valid_d = 1'b1;
        end else begin
            inst_d  = {XLEN{1'b0}};
            pcim_d  = {IMM_W{1'b0}};
            valid_d = 1'b0;
        end
    end

    // Control state and output slot registers
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            pc_q     <= {XLEN{1'b0}};
            inst_q   <= {XLEN{1'b0}};
            pcim_q   <= {IMM_W{1'b0}};
            valid_q  <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            pcim_q   <= pcim_d;
            valid_q  <= valid_d;
        end
    end

    // Queue storage; contents are don't-care after reset, so it carries none
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            pc_mem_q[wr_ptr_q]   <= pc_i;
            inst_mem_q[wr_ptr_q] <= inst_i;
            pcim_mem_q[wr_ptr_q] <= pcIm_i;
        end
    end

    assign ready_o = ready_s;
    assign pc_o    = pc_q;
    assign inst_o  = inst_q;
    assign pcIm_o  = pcim_q;
    assign valid_o = valid_q;
    assign count_o = count_q;

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised, elastic IF/ID boundary.
- A DEPTH-entry FIFO of {pc, inst, pcIm} records sits in front of a registered ID-stage output slot.
- IF keeps fetching while ID is stalled by a hazard, up to DEPTH instructions.
- Flush empties the queue and inserts a NOP bubble (inst 0), as the existing IF/ID boundary does.

Parameters:
- XLEN, 32, width of pc and instruction fields.
- IMM_W, 12, width of the branch-immediate sideband pcIm.
- DEPTH, 4, queue entries; power of two, >= 2. Derived: CNT_W = clog2(DEPTH)+1.

Ports:
- clk_i  in  1  clock, rising-edge.
- start_i  in  1  asynchronous active-low reset (0 = reset).
- flush_i  in  1  discard queue and output slot; inject bubble.
- hazard_i  in  1  ID stall; output slot holds, no pop.
- push_i  in  1  IF presents a valid instruction this cycle.
- ready_o  out  1  queue can accept push; = (count_o < DEPTH).
- pc_i  in  XLEN  fetched pc.
- inst_i  in  XLEN  fetched instruction.
- pcIm_i  in  IMM_W  fetched branch immediate.
- pc_o  out  XLEN  ID-stage pc.
- inst_o  out  XLEN  ID-stage instruction (0 = bubble).
- pcIm_o  out  IMM_W  ID-stage immediate.
- valid_o  out  1  output slot holds a real instruction.
- count_o  out  CNT_W  entries currently queued (output slot excluded).

Behaviour:
- Reset (start_i=0, async):
  - pc_o, inst_o, pcIm_o, valid_o and count_o go to 0.
  - Read and write pointers go to 0.
  - Storage contents are don't-care.
- A push is accepted only when push_i=1 and ready_o=1. When full, the push is dropped: no write, no error flag. IF must stall on !ready_o.
- ready_o depends on the registered count only. A pop in the same cycle does not raise ready_o.
- Priority per rising edge: reset > flush_i > hazard_i > normal.
- Flush (flush_i=1):
  - count and pointers go to 0.
  - inst_o=0, pcIm_o=0, valid_o=0, pc_o<=pc_i.
  - Any push in the same cycle is ignored.
- Hazard (hazard_i=1, no flush):
  - Output slot holds all fields including valid_o.
  - An accepted push is enqueued at the tail; count+1.
- Normal (hazard_i=0, no flush), in order of precedence:
  - count>0: output slot <= head entry, valid_o=1, pop. If a push is also accepted, it is written at the tail in the same edge, so count is unchanged. Otherwise count-1.
  - count=0 and push accepted: bypass. Output slot <= {pc_i, inst_i, pcIm_i}, valid_o=1. Nothing is enqueued. Latency is 1 cycle, identical to a plain pipeline register.
  - count=0 and no push: bubble. inst_o=0, pcIm_o=0, valid_o=0, pc_o holds its value.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH and never under- or overflows.
- FIFO order is strictly preserved. No instruction is duplicated or skipped except by flush.
- Outputs change only on clk_i edges or async reset. There are no combinational paths from data inputs to outputs. ready_o is a function of count only.
- Reset asserted mid-stream discards everything immediately. After release, the first accepted push bypasses to the output.

Test Plan:
- Reset then stream: start_i 0→1, push pc=0x0/0x4/0x8 with inst=0x00A00093/0x00100113/0x002081B3 on consecutive cycles, hazard_i=0 -> inst_o shows each instruction one cycle after its push, count_o stays 0, valid_o=1.
- Stall fill: hazard_i=1 for 5 cycles while pushing pc 0x10..0x20 (DEPTH=4) -> count_o reaches 4, ready_o=0, the 5th push (pc=0x20) is dropped. After hazard_i falls, pc_o steps 0x10, 0x14, 0x18, 0x1C, then a bubble (inst_o=0, valid_o=0).
- Simultaneous push/pop: count_o=2, hazard_i=0, push pc=0x40 -> count_o stays 2, pc_o becomes the old head, and pc=0x40 appears after the two older entries.
- Flush while full: count_o=4, flush_i=1, push_i=1, pc_i=0x80 -> next cycle count_o=0, inst_o=0, pcIm_o=0, valid_o=0, pc_o=0x80, ready_o=1. The pushed instruction never appears.
- Flush beats hazard: flush_i=1 and hazard_i=1 together -> same result as plain flush.
- Async reset mid-operation: count_o=3, drop start_i between clock edges -> all outputs 0 immediately without a clock edge. After release, push pc=0x100 appears at pc_o one cycle later.
